dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Three-requester data-memory arbiter with burst limiting and one-cycle read return.
// Define DMEM_ARB_RR_EN for round-robin order; default build is fixed priority 0 > 1 > 2.
module dmem_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          req,
    input  logic [2:0]          we,
    input  logic [3*ADDR_W-1:0] addr,
    input  logic [3*DATA_W-1:0] wdata,
    output logic [2:0]          gnt,
    output logic [2:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [1:0]       last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [2:0]       rd_pend_q, rd_pend_d;
    logic [2:0]       holder, elig;
    logic [1:0]       gnt_idx;
    logic             gnt_any;
`ifdef DMEM_ARB_RR_EN
    logic [1:0]       rr_idx;
`endif

    always_comb begin
        holder  = 3'b001 << last_gnt_q;
        elig    = req;
        // A holder that used up its burst steps aside only if someone else is waiting.
        if (burst_cnt_q == CNT_W'(MAX_BURST) && |(req & ~holder))
            elig = req & ~holder;
        gnt     = '0;
        gnt_idx = '0;
`ifdef DMEM_ARB_RR_EN
        rr_idx  = '0;
`endif
        if (!reset) begin
`ifdef DMEM_ARB_RR_EN
            for (int k = 3; k >= 1; k--) begin
                rr_idx = 2'((int'(last_gnt_q) + k) % 3);
                if (elig[rr_idx]) begin
                    gnt     = 3'b001 << rr_idx;
                    gnt_idx = rr_idx;
                end
            end
`else
            for (int i = 2; i >= 0; i--) begin
                if (elig[i]) begin
                    gnt     = 3'b001 << i;
                    gnt_idx = 2'(i);
                end
            end
`endif
        end
    end

    assign gnt_any   = |gnt;
    assign mem_en    = gnt_any;
    assign mem_we    = gnt_any ? we[gnt_idx] : 1'b0;
    assign mem_addr  = gnt_any ? addr[gnt_idx*ADDR_W +: ADDR_W] : '0;
    assign mem_wdata = gnt_any ? wdata[gnt_idx*DATA_W +: DATA_W] : '0;

    always_comb begin
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = '0;
        rd_pend_d   = mem_we ? 3'b000 : gnt;
        if (gnt_any) begin
            last_gnt_d = gnt_idx;
            if (gnt_idx != last_gnt_q)
                burst_cnt_d = CNT_W'(1);
            else if (burst_cnt_q == CNT_W'(MAX_BURST))
                burst_cnt_d = burst_cnt_q;
            else
                burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q  <= 2'd2;
            burst_cnt_q <= '0;
            rd_pend_q   <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    // Masking with reset drops a read return that would land in a reset cycle.
    assign rvalid = reset ? 3'b000 : rd_pend_q;
    assign rdata  = (|rvalid) ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a rule-level reference model, plus directed cases.
module tb_dmem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    req, we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]    gnt, rvalid;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;

    int total = 0;
    int bad   = 0;

    // reference model state
    int         m_last;
    int         m_cnt;
    logic [2:0] m_pend;
    logic [2:0] last_eg;

    logic [2:0]    obs_gnt, obs_rvalid;
    logic [DW-1:0] obs_rdata, obs_wdata;
    logic [AW-1:0] obs_addr;
    logic          obs_en, obs_we;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Grant from the rules: scan in priority order, skipping an exhausted holder when others wait.
    function automatic logic [2:0] model_gnt(input logic [2:0] r);
        logic others;
        int   c;
        if (reset) return 3'b000;
        others = (r & ~(3'b001 << m_last)) != 3'b000;
        for (int k = 0; k < 3; k++) begin
`ifdef DMEM_ARB_RR_EN
            c = (m_last + 1 + k) % 3;
`else
            c = k;
`endif
            if (r[c] && !(c == m_last && m_cnt == MB && others))
                return 3'b001 << c;
        end
        return 3'b000;
    endfunction

    task automatic step();
        logic [2:0]    eg, erv;
        int            gi;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, erd;
        eg  = model_gnt(req);
        gi  = eg[0] ? 0 : (eg[1] ? 1 : 2);
        ewe = (eg != 0) ? we[gi] : 1'b0;
        ea  = (eg != 0) ? addr[gi*AW +: AW] : '0;
        ed  = (eg != 0) ? wdata[gi*DW +: DW] : '0;
        erv = reset ? 3'b000 : m_pend;
        erd = (erv != 0) ? mem_rdata : '0;
        @(negedge clk);
        obs_gnt = gnt; obs_rvalid = rvalid; obs_rdata = rdata;
        obs_en = mem_en; obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("mem_en", 64'(mem_en), 64'(eg != 0));
        chk("mem_we", 64'(mem_we), 64'(ewe));
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("rvalid", 64'(rvalid), 64'(erv));
        chk("rdata", rdata, erd);
        @(posedge clk);
        if (reset) begin
            m_last = 2; m_cnt = 0; m_pend = 3'b000;
        end else begin
            if (eg == 0) m_cnt = 0;
            else if (gi == m_last && m_cnt > 0) m_cnt = (m_cnt + 1 > MB) ? MB : m_cnt + 1;
            else m_cnt = 1;
            if (eg != 0) m_last = gi;
            m_pend = ewe ? 3'b000 : eg;
        end
        last_eg = eg;
        #1;
    endtask

    task automatic new_req(input int i);
        req[i] = 1'b1;
        we[i]  = 1'($urandom_range(1));
        addr[i*AW +: AW]  = {$urandom, $urandom};
        wdata[i*DW +: DW] = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; we = '0;
        step();
        reset = 1'b0;
    endtask

    logic [2:0] e36 [8];
    logic [2:0] e35g [5];
    logic [2:0] e35v [5];

    initial begin
        m_last = 2; m_cnt = 0; m_pend = '0; last_eg = '0;
        reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; mem_rdata = '0;
        step();
        reset = 1'b0;

        // reset state
        step();
        chk("rst_rvalid", 64'(obs_rvalid), 64'd0);
        chk("rst_rdata", obs_rdata, 64'd0);
        chk("rst_en", 64'(obs_en), 64'd0);

        // single read with one-cycle return
        do_reset();
        req = 3'b001; we = 3'b000; addr[0 +: AW] = 64'h10;
        step();
        chk("rd_gnt", 64'(obs_gnt), 64'h1);
        chk("rd_addr", obs_addr, 64'h10);
        req = 3'b000; mem_rdata = 64'hAB;
        step();
        chk("rd_rvalid", 64'(obs_rvalid), 64'h1);
        chk("rd_rdata", obs_rdata, 64'hAB);

        // write from requester 1
        req = 3'b010; we = 3'b010; addr[AW +: AW] = 64'h200; wdata[DW +: DW] = 64'h55;
        step();
        chk("wr_we", 64'(obs_we), 64'h1);
        chk("wr_addr", obs_addr, 64'h200);
        chk("wr_wdata", obs_wdata, 64'h55);
        req = 3'b000; we = 3'b000;
        step();
        chk("wr_rvalid", 64'(obs_rvalid), 64'h0);

        // read to requester 2, then reset kills the return
        req = 3'b100; we = 3'b000; addr[2*AW +: AW] = 64'h3000;
        step();
        chk("rr2_gnt", 64'(obs_gnt), 64'h4);
        reset = 1'b1; mem_rdata = 64'hDEAD;
        step();
        chk("kill_gnt", 64'(obs_gnt), 64'h0);
        chk("kill_rvalid", 64'(obs_rvalid), 64'h0);
        chk("kill_rdata", obs_rdata, 64'h0);
        reset = 1'b0; req = 3'b000;

        // idle cycles
        for (int c = 0; c < 5; c++) begin
            step();
            chk("idle_gnt", 64'(obs_gnt), 64'h0);
            chk("idle_en", 64'(obs_en), 64'h0);
        end

`ifdef DMEM_ARB_RR_EN
        do_reset();
        e35g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        e35v = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
        req = 3'b111; we = 3'b000;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("rr_gnt", 64'(obs_gnt), 64'(e35g[c]));
            chk("rr_rvalid", 64'(obs_rvalid), 64'(e35v[c]));
        end
`else
        do_reset();
        e36 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001, 3'b001, 3'b001};
        req = 3'b101; we = 3'b000;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("burst_gnt", 64'(obs_gnt), 64'(e36[c]));
            if (c == 4) req[2] = 1'b0;
        end
`endif

        // randomized traffic with occasional reset
        do_reset();
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (last_eg[i]) begin
                    if ($urandom_range(1) == 1) new_req(i);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(9) < 4) begin
                    new_req(i);
                end
            end
            reset = ($urandom_range(49) == 0);
            mem_rdata = {$urandom, $urandom};
            step();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
